// File: rtl/cpu_div_cell.sv
// cpu_div_cell: radix-2 restoring 32-bit divider for div/divu, one quotient bit per clock.
//   clk, reset (async, active-high)
//   A_div_src1/A_div_src2/div_signed/div_start : operands and request, sampled on acceptance
//   div_busy/div_done                          : stall and completion handshake
//   A_div_cell_result/A_div_cell_remainder     : quotient and remainder, held until next FIXUP
//   div_by_zero                                : last completed operation had a zero divisor
module cpu_div_cell #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] A_div_src1,
   input  logic [DATA_WIDTH-1:0] A_div_src2,
   input  logic                  div_signed,
   input  logic                  div_start,
   output logic                  div_busy,
   output logic                  div_done,
   output logic [DATA_WIDTH-1:0] A_div_cell_result,
   output logic [DATA_WIDTH-1:0] A_div_cell_remainder,
   output logic                  div_by_zero
);
   localparam int CW = $clog2(DATA_WIDTH);
   typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
   state_t                state, state_nx;
   logic [DATA_WIDTH-1:0] dvd, dvs, rem;
   logic [CW-1:0]         cnt;
   logic                  q_neg, r_neg, dz, accept;
   logic [DATA_WIDTH:0]   rem_sh, trial;
   always_comb begin
      accept   = div_start && (state == IDLE || state == DONE);
      state_nx = accept ? CALC :
                 state == CALC ? (cnt == CW'(DATA_WIDTH-1) ? FIXUP : CALC) :
                 state == FIXUP ? DONE : IDLE;
      // shifted remainder keeps its carry bit so divisors near 2^32 still compare correctly
      rem_sh   = {rem, dvd[DATA_WIDTH-1]};
      trial    = rem_sh - {1'b0, dvs};
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state                <= IDLE;
         dvd                  <= '0;
         dvs                  <= '0;
         rem                  <= '0;
         cnt                  <= '0;
         q_neg                <= 1'b0;
         r_neg                <= 1'b0;
         dz                   <= 1'b0;
         div_busy             <= 1'b0;
         div_done             <= 1'b0;
         A_div_cell_result    <= '0;
         A_div_cell_remainder <= '0;
         div_by_zero          <= 1'b0;
      end else begin
         state    <= state_nx;
         div_busy <= state_nx == CALC || state_nx == FIXUP;
         div_done <= state_nx == DONE;
         if (accept) begin
            dvd   <= (div_signed && A_div_src1[DATA_WIDTH-1]) ? -A_div_src1 : A_div_src1;
            dvs   <= (div_signed && A_div_src2[DATA_WIDTH-1]) ? -A_div_src2 : A_div_src2;
            q_neg <= div_signed && (A_div_src1[DATA_WIDTH-1] ^ A_div_src2[DATA_WIDTH-1]);
            r_neg <= div_signed && A_div_src1[DATA_WIDTH-1];
            dz    <= A_div_src2 == '0;
            rem   <= '0;
            cnt   <= '0;
         end else if (state == CALC) begin
            rem <= trial[DATA_WIDTH] ? rem_sh[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
            dvd <= {dvd[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};
            cnt <= cnt + 1'b1;
         end else if (state == FIXUP) begin
            // a zero divisor yields an all-ones magnitude; the negation sense flips so that
            // unsigned x/0 gives 1 and signed negative x/0 gives all ones
            A_div_cell_result    <= (q_neg ^ dz) ? -dvd : dvd;
            A_div_cell_remainder <= r_neg ? -rem : rem;
            div_by_zero          <= dz;
         end
      end
   end
endmodule

// File: doc/cpu_div_cell.md
# cpu_div_cell

Iterative 32-bit integer divider for the CPU's A-stage execute path. It is the counterpart of the multiply cell and serves the `div`/`divu` instructions. Radix-2 restoring algorithm: one quotient bit per clock, with a start/done handshake. The pipeline stalls on `div_busy` and captures the quotient and remainder on `div_done`.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand/result width; iteration count equals `DATA_WIDTH`.

Ports:
- `clk`  in  1  single clock for all state; rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `A_div_src1`  in  DATA_WIDTH  dividend; sampled only on accepted start.
- `A_div_src2`  in  DATA_WIDTH  divisor; sampled only on accepted start.
- `div_signed`  in  1  1 = two's-complement divide, 0 = unsigned; sampled with operands.
- `div_start`  in  1  request; accepted only in IDLE or DONE.
- `div_busy`  out  1  high from the cycle after acceptance through FIXUP.
- `div_done`  out  1  one-cycle pulse; results valid from this cycle on.
- `A_div_cell_result`  out  DATA_WIDTH  quotient.
- `A_div_cell_remainder`  out  DATA_WIDTH  remainder.
- `div_by_zero`  out  1  divisor was zero for the last completed operation.

Clocking and reset: one clock; reset is asynchronous and active-high.

## Operation
- States: IDLE, CALC, FIXUP, DONE.
  - IDLE: waits for start.
  - CALC: runs `DATA_WIDTH` iterations.
  - FIXUP: applies signs and writes the output registers.
  - DONE: one cycle, `div_done`=1.
- Acceptance: on `div_start`=1 in IDLE or DONE:
  - Latch the magnitudes: |src1| and |src2| when `div_signed`, else the raw values.
  - Latch `q_neg` = signed & (src1[31]^src2[31]) and `r_neg` = signed & src1[31].
  - Latch the zero-divisor flag.
  - Clear the partial remainder and the iteration counter; go to CALC.
- CALC iteration:
  - Shift {rem, dvd} left by 1.
  - Trial = rem − divisor, computed (DATA_WIDTH+1) bits wide.
  - If trial is non-negative, rem ← trial and shift in quotient bit 1; else shift in 0.
  - The counter increments each cycle. After the iteration with counter = `DATA_WIDTH`−1, go to FIXUP.
- FIXUP:
  - `A_div_cell_result` ← q_neg ? −q : q.
  - `A_div_cell_remainder` ← r_neg ? −r : r.
  - `div_by_zero` ← latched flag. Go to DONE.
- DONE: go to IDLE next cycle unless `div_start`=1, which is accepted here (back-to-back operations).
- Rounding: truncation toward zero; remainder takes the dividend's sign; |remainder| < |divisor|.
- Divide by zero:
  - No special path; the full latency is kept.
  - Quotient = 0xFFFFFFFF when signed and src1 negative, else 0x00000001.
  - Remainder = `A_div_src1` as given.
  - `div_by_zero`=1.
  - This is the natural restoring result after sign fixup; the implementation must match it exactly.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. Magnitude 0x80000000 is handled as unsigned 2^31.
- `div_start` while in CALC or FIXUP is ignored; no queuing.
- Outputs hold their last values until the next FIXUP overwrites them.

## Timing
- Reset values: state IDLE, `div_busy`=0, `div_done`=0, `A_div_cell_result`=0, `A_div_cell_remainder`=0, `div_by_zero`=0, counter 0.
- Latency: start sampled at edge E0 → `div_done`=1 during the cycle after edge E0+`DATA_WIDTH`+1. That is 33 clocks for 32 bits.
- `div_busy`=1 for exactly `DATA_WIDTH`+1 cycles (CALC + FIXUP); it is 0 in IDLE and DONE.
- Throughput: one operation per `DATA_WIDTH`+2 cycles when started from DONE.
- Operands may change freely after the acceptance edge.
- Reset asserted mid-operation:
  - Immediate return to IDLE with all outputs at reset values.
  - No `div_done` pulse.
  - A start in the first cycle after deassertion is accepted normally.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Unsigned 100 / 7 → quotient 14, remainder 2, `div_by_zero`=0, `div_done` exactly 33 cycles after start, `div_busy` high for 33 cycles.
- Signed −7 / 2 (0xFFFFFFF9 / 0x2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Signed 7 / −2 → quotient 0xFFFFFFFD, remainder 0x1.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Unsigned 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- Divide by zero, unsigned 1234 / 0 → quotient 0x00000001, remainder 1234, `div_by_zero`=1, normal latency.
- Divide by zero, signed −5 / 0 → quotient 0xFFFFFFFF, remainder 0xFFFFFFFB, `div_by_zero`=1.
- Second `div_start` at cycle 10 of a busy operation → ignored; first result correct; single `div_done` pulse.
- Back-to-back: new start issued in the DONE cycle → second `div_done` 33 cycles later with the correct result.
- `reset` pulsed at cycle 15 of an operation → outputs return to 0 asynchronously; no `div_done`. A following 100 / 7 completes normally.
- Random unsigned/signed sweep (10k operations) against a reference model with truncation semantics → zero mismatches.
